// File: rtl/surface_pts_serializer.sv
// Buffers one ray's surface point set and streams it out one {z,y,x} point per beat.
// Optional macro SURF_DEPTH_GATE_EN drops rays whose gt_depth is not positive.
module surface_pts_serializer #(
    parameter int N_SURFACE  = 16,
    parameter int TOTAL_BITS = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [3*N_SURFACE*TOTAL_BITS-1:0] in_pts,
    input  logic [TOTAL_BITS-1:0]             in_depth,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [3*TOTAL_BITS-1:0]           out_pt,
    output logic [$clog2(N_SURFACE)-1:0]      out_idx,
    output logic                              out_last,
    output logic [7:0]                        out_ray_id
);

    localparam int IDX_W = $clog2(N_SURFACE);
    localparam int PT_W  = 3 * TOTAL_BITS;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state;
    logic [PT_W-1:0]  pts_q [N_SURFACE];
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       ray_id_q;

    logic out_xfer;
    logic last_xfer;
    logic accept;
    logic depth_ok;
    logic load;

`ifdef SURF_DEPTH_GATE_EN
    assign depth_ok = ($signed(in_depth) > 0);
`else
    logic unused_depth;
    assign unused_depth = ^in_depth;
    assign depth_ok     = 1'b1;
`endif

    assign out_valid  = (state == STREAM);
    assign out_last   = (idx_q == IDX_W'(N_SURFACE - 1));
    assign out_idx    = idx_q;
    assign out_pt     = pts_q[idx_q];
    assign out_ray_id = ray_id_q;

    assign out_xfer  = out_valid && out_ready;
    assign last_xfer = out_xfer && out_last;
    // Ready is forced low during reset; the last beat frees the buffer for a back-to-back ray.
    assign in_ready  = rst_n && ((state == IDLE) || last_xfer);
    assign accept    = in_valid && in_ready;
    assign load      = accept && depth_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= '0;
            ray_id_q <= '0;
            for (int unsigned i = 0; i < N_SURFACE; i++) begin
                pts_q[i] <= '0;
            end
        end else begin
            if (last_xfer) begin
                ray_id_q <= ray_id_q + 8'd1;
            end
            if (load) begin
                state <= STREAM;
                idx_q <= '0;
                for (int unsigned i = 0; i < N_SURFACE; i++) begin
                    pts_q[i] <= in_pts[i*PT_W +: PT_W];
                end
            end else if (last_xfer) begin
                state <= IDLE;
                idx_q <= '0;
            end else if (out_xfer) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_surface_pts_serializer.sv
// Self-checking bench for surface_pts_serializer: vector table of rays plus
// hand-written back-to-back, mid-stream reset, depth-gate and ray_id wrap sequences.
module tb_surface_pts_serializer;

    localparam int N    = 16;
    localparam int TB   = 16;
    localparam int PT_W = 3 * TB;

`ifdef SURF_DEPTH_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3*N*TB-1:0] in_pts;
    logic [TB-1:0]     in_depth;
    logic              out_valid;
    logic              out_ready;
    logic [PT_W-1:0]   out_pt;
    logic [3:0]        out_idx;
    logic              out_last;
    logic [7:0]        out_ray_id;

    surface_pts_serializer #(.N_SURFACE(N), .TOTAL_BITS(TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pts(in_pts), .in_depth(in_depth),
        .out_valid(out_valid), .out_ready(out_ready), .out_pt(out_pt),
        .out_idx(out_idx), .out_last(out_last), .out_ray_id(out_ray_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PT_W-1:0] pt;
        logic [3:0]      idx;
        logic            last;
    } beat_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] depth;
        int          mode;
        int          exp_beats;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[6];

    int          checks = 0;
    int          errors = 0;
    int          beats_seen;
    int          cyc = 0;
    bit          accepted;
    logic [15:0] cur_base;
    logic [15:0] cur_depth;
    logic [7:0]  exp_id = 8'd0;
    bit          prev_stall = 1'b0;
    logic [PT_W-1:0] prev_pt;
    logic [3:0]      prev_idx;
    logic            prev_last;
    logic [7:0]      prev_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3*N*TB-1:0] mk_pts(input logic [15:0] base);
        logic [3*N*TB-1:0] v;
        for (int w = 0; w < 3 * N; w++) begin
            v[w*TB +: TB] = 16'(base + 16'(w));
        end
        return v;
    endfunction

    function automatic bit gate_pass(input logic [15:0] d);
        return !GATE || ($signed(d) > 0);
    endfunction

    function automatic logic drive_ready(input int mode);
        case (mode)
            1:       return cyc[0];
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    // Inputs are set at the falling edge; outputs checked 1 ns later, then one clock.
    task automatic tick();
        bit exp_ready;
        beat_t e;
        #1;
        if (rst_n) begin
            exp_ready = (sb.size() == 0);
            if (sb.size() != 0) exp_ready = out_ready && sb[0].last;
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (prev_stall && out_valid) begin
                chk("hold_pt", 64'(out_pt), 64'(prev_pt));
                chk("hold_idx", 64'(out_idx), 64'(prev_idx));
                chk("hold_last", 64'(out_last), 64'(prev_last));
                chk("hold_id", 64'(out_ray_id), 64'(prev_id));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_pt", 64'(out_pt), 64'(e.pt));
                chk("beat_idx", 64'(out_idx), 64'(e.idx));
                chk("beat_last", 64'(out_last), 64'(e.last));
                chk("beat_id", 64'(out_ray_id), 64'(exp_id));
                if (e.last) exp_id = exp_id + 8'd1;
                beats_seen++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pt = out_pt; prev_idx = out_idx; prev_last = out_last; prev_id = out_ray_id;
            if (in_valid && exp_ready) begin
                accepted = 1'b1;
                if (gate_pass(cur_depth)) begin
                    for (int j = 0; j < N; j++) begin
                        e.pt   = {16'(cur_base + 16'(3*j+2)), 16'(cur_base + 16'(3*j+1)),
                                  16'(cur_base + 16'(3*j))};
                        e.idx  = 4'(j);
                        e.last = (j == N - 1);
                        sb.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic offer(input logic [15:0] base, input logic [15:0] depth, input int mode);
        int n;
        cur_base  = base;
        cur_depth = depth;
        in_pts    = mk_pts(base);
        in_depth  = depth;
        in_valid  = 1'b1;
        accepted  = 1'b0;
        n = 0;
        while (!accepted && n < 200) begin
            out_ready = drive_ready(mode);
            tick();
            n++;
        end
        if (!accepted) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int mode);
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            out_ready = drive_ready(mode);
            tick();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        out_ready = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_ray_id", 64'(out_ray_id), 64'd0);
        chk("rst_out_pt", 64'(out_pt), 64'd0);
        sb.delete();
        exp_id = 8'd0;
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{16'h0000, 16'h0050, 0, N};
        tbl[1] = '{16'h1000, 16'h0050, 1, N};
        tbl[2] = '{16'hF000, 16'h0000, 0, GATE ? 0 : N};
        tbl[3] = '{16'h0100, 16'h0050, 2, N};
        tbl[4] = '{16'h7FF0, 16'hFFF0, 2, GATE ? 0 : N};
        tbl[5] = '{16'h8000, 16'h0001, 2, N};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pts = '0; in_depth = '0; cur_base = '0; cur_depth = '0;
        @(negedge clk);
        do_reset();

        // Basic ray: words 3*j+k, out_ready held high.
        beats_seen = 0;
        offer(16'h0000, 16'h0050, 0);
        drain(0);
        chk("basic_beats", 64'(beats_seen), 64'(N));
        chk("basic_id_after", 64'(out_ray_id), 64'd1);

        for (int i = 0; i < 6; i++) begin
            beats_seen = 0;
            offer(tbl[i].base, tbl[i].depth, tbl[i].mode);
            drain(tbl[i].mode);
            chk($sformatf("vec%0d_beats", i), 64'(beats_seen), 64'(tbl[i].exp_beats));
        end

        // Back-to-back rays with in_valid held high.
        do_reset();
        beats_seen = 0;
        offer(16'h2000, 16'h0050, 0);
        offer(16'h3000, 16'h0050, 0);
        drain(0);
        chk("b2b_beats", 64'(beats_seen), 64'(2 * N));
        chk("b2b_id_after", 64'(out_ray_id), 64'd2);

        // Reset asserted after beat 5 of a ray.
        offer(16'h4000, 16'h0050, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        do_reset();
        beats_seen = 0;
        offer(16'h5000, 16'h0050, 0);
        drain(0);
        chk("postrst_beats", 64'(beats_seen), 64'(N));
        chk("postrst_id_after", 64'(out_ray_id), 64'd1);

        // Depth gate: zero depth then 5.0.
        do_reset();
        offer(16'h6000, 16'h0000, 0);
        drain(0);
        offer(16'h6100, 16'h0050, 0);
        drain(0);
        chk("gate_id_after", 64'(out_ray_id), GATE ? 64'd1 : 64'd2);

        // ray_id wrap over 257 rays.
        do_reset();
        for (int r = 0; r < 256; r++) begin
            offer(16'(r * 7), 16'h0050, 0);
            drain(0);
        end
        chk("wrap_id_256", 64'(out_ray_id), 64'd0);
        offer(16'hABC0, 16'h0050, 0);
        drain(0);
        chk("wrap_id_257", 64'(out_ray_id), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
